// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write sequencer: turns each LSU store into one
// timed bus write (setup, enable pulse, hold, execution wait) with a one-deep pending buffer.
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CNT_W   = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    input  logic        i_wr_stb,
    input  logic        i_ovf_clr,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overflow
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    // Counter is loaded with duration-1 on state entry and the state ends when it reaches zero.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic [8:0]       pend_cmd, pend_cmd_nxt;
    logic [8:0]       cmd_nxt;
    logic             cmd_ld;
    logic             drop;
    logic             last;
    logic             exec_end;
    logic             long_cmd;
    logic [8:0]       new_word;
    logic             unused_word_bits;

    assign new_word         = {i_lcd_word[9], i_lcd_word[7:0]};
    assign unused_word_bits = ^{i_lcd_word[30:10], i_lcd_word[8]};
    assign last             = (cnt == '0);
    assign exec_end         = (state == EXEC) && last;
    assign long_cmd         = !o_lcd_rs && (o_lcd_data inside {8'h01, 8'h02, 8'h03});
    assign o_busy           = (state != IDLE) || pend_vld;
    assign o_lcd_rw         = 1'b0;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_vld_nxt = pend_vld;
        pend_cmd_nxt = pend_cmd;
        cmd_ld       = 1'b0;
        cmd_nxt      = new_word;
        drop         = 1'b0;

        case (state)
            IDLE: begin
                if (i_wr_stb) begin
                    cmd_ld    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                end
            end
            SETUP: begin
                if (last) begin
                    state_nxt = PULSE;
                    cnt_nxt   = LD_EN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (last) begin
                    state_nxt = HOLD;
                    cnt_nxt   = LD_HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_nxt = EXEC;
                    cnt_nxt   = long_cmd ? LD_CLEAR : LD_EXEC;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            EXEC: begin
                if (last) begin
                    if (pend_vld) begin
                        cmd_ld       = 1'b1;
                        cmd_nxt      = pend_cmd;
                        pend_vld_nxt = 1'b0;
                        state_nxt    = SETUP;
                        cnt_nxt      = LD_SETUP;
                    end else if (i_wr_stb) begin
                        cmd_ld    = 1'b1;
                        state_nxt = SETUP;
                        cnt_nxt   = LD_SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // On the last EXEC cycle the pending slot is freed in the same edge, so a
        // strobe then refills it instead of being dropped (bypass case excluded).
        if (i_wr_stb && (state != IDLE) && !(exec_end && !pend_vld)) begin
            if (!pend_vld || exec_end) begin
                pend_vld_nxt = 1'b1;
                pend_cmd_nxt = new_word;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_vld   <= 1'b0;
            pend_cmd   <= '0;
            o_lcd_data <= '0;
            o_lcd_rs   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_vld <= pend_vld_nxt;
            pend_cmd <= pend_cmd_nxt;
            if (cmd_ld) {o_lcd_rs, o_lcd_data} <= cmd_nxt;
            o_lcd_en <= (state_nxt == PULSE);
            o_lcd_on <= i_lcd_word[31];
            if (drop)           o_overflow <= 1'b1;
            else if (i_ovf_clr) o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed and random checks of lcd_ctrl against a schedule-based model of
// the write timeline (accept edge, phase offsets, pending slot, sticky overflow).
module tb_lcd_ctrl;

    localparam int TS = 2, TE = 12, TH = 2, TX = 40, TC = 150, CW = 17;
    localparam int L  = TS + TE + TH + TX;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_lcd_word = '0;
    logic        i_wr_stb = 1'b0;
    logic        i_ovf_clr = 1'b0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow;

    lcd_ctrl #(.T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_CLEAR(TC), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_lcd_word(i_lcd_word), .i_wr_stb(i_wr_stb),
        .i_ovf_clr(i_ovf_clr), .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;

    // Model: active command with its accept edge, one pending slot, sticky overflow.
    bit         m_act, m_pend, m_ovf, m_on;
    logic [8:0] m_cmd, m_pcmd;
    int         m_start, edge_n;
    logic [31:0] cur_w = '0;

    function automatic int cmd_len(logic [8:0] c);
        bit lng = (c[8] == 1'b0) && (c[7:0] inside {8'h01, 8'h02, 8'h03});
        return TS + TE + TH + (lng ? TC : TX);
    endfunction

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_ovf = 0; m_on = 0; m_cmd = '0; m_pcmd = '0; m_start = 0;
    endtask

    task automatic model_edge(bit stb, logic [31:0] w, bit clr);
        logic [8:0] nw = {w[9], w[7:0]};
        bit drop = 0;
        edge_n++;
        if (m_act && edge_n == m_start + cmd_len(m_cmd)) begin
            if (m_pend) begin
                m_cmd = m_pcmd; m_start = edge_n; m_pend = stb; m_pcmd = nw;
            end else if (stb) begin
                m_cmd = nw; m_start = edge_n;
            end else begin
                m_act = 0;
            end
        end else if (!m_act) begin
            if (stb) begin m_act = 1; m_cmd = nw; m_start = edge_n; end
        end else if (stb) begin
            if (!m_pend) begin m_pend = 1; m_pcmd = nw; end
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_on = w[31];
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ph = edge_n - m_start + 1;
        chk("data", 32'(o_lcd_data), 32'(m_cmd[7:0]));
        chk("rs", 32'(o_lcd_rs), 32'(m_cmd[8]));
        chk("rw", 32'(o_lcd_rw), 32'd0);
        chk("en", 32'(o_lcd_en), 32'(m_act && ph >= TS + 1 && ph <= TS + TE));
        chk("on", 32'(o_lcd_on), 32'(m_on));
        chk("busy", 32'(o_busy), 32'(m_act || m_pend));
        chk("ovf", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic step(bit stb, logic [31:0] w, bit clr);
        cur_w = w;
        i_wr_stb = stb; i_lcd_word = w; i_ovf_clr = clr;
        @(posedge i_clk);
        model_edge(stb, w, clr);
        @(negedge i_clk);
        check_all();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, cur_w, 0);
    endtask

    initial begin
        int first_en, en_cnt, last_busy, busy_fall, s2, s3, saw43;
        logic [31:0] w;
        bit stb, clr;
        model_reset();
        edge_n = 0;

        // Reset state
        @(negedge i_clk); @(negedge i_clk);
        check_all();
        i_reset = 1'b1;

        // Single data write: EN on cycles TS+1..TS+TE, busy through cycle L
        step(1, 32'h8000_0241, 0);
        chk("w1_data", 32'(o_lcd_data), 32'h41);
        chk("w1_rs", 32'(o_lcd_rs), 32'd1);
        chk("w1_busy_rise", 32'(o_busy), 32'd1);
        first_en = 0; en_cnt = 0; last_busy = 0;
        for (int cyc = 2; cyc <= L + 2; cyc++) begin
            step(0, 32'h8000_0000, 0);
            if (o_lcd_en) begin
                if (first_en == 0) first_en = cyc;
                en_cnt++;
            end
            if (o_busy) last_busy = cyc;
        end
        chk("w1_en_first", first_en, TS + 1);
        chk("w1_en_width", en_cnt, TE);
        chk("w1_busy_last", last_busy, L);
        chk("w1_on", 32'(o_lcd_on), 32'd1);

        // Clear command uses the long execution time
        step(1, 32'h8000_0001, 0);
        busy_fall = 0;
        for (int cyc = 2; cyc <= TS + TE + TH + TC + 5; cyc++) begin
            step(0, 32'h8000_0000, 0);
            if (!o_busy && busy_fall == 0) busy_fall = cyc;
        end
        chk("clr_idle_cycle", busy_fall, TS + TE + TH + TC + 1);
        chk("clr_rs", 32'(o_lcd_rs), 32'd0);

        // Three back-to-back strobes: third is dropped
        step(1, 32'h8000_0241, 0);
        step(1, 32'h8000_0242, 0);
        step(1, 32'h8000_0243, 0);
        chk("b2b_ovf", 32'(o_overflow), 32'd1);
        s2 = 0; saw43 = 0;
        for (int cyc = 4; cyc <= 2 * L + 2; cyc++) begin
            step(0, 32'h8000_0000, 0);
            if (o_lcd_data == 8'h42 && s2 == 0) s2 = cyc;
            if (o_lcd_data == 8'h43) saw43 = 1;
        end
        chk("b2b_second_setup", s2, L + 1);
        chk("b2b_dropped", saw43, 0);
        chk("b2b_idle", 32'(o_busy), 32'd0);
        chk("b2b_ovf_sticky", 32'(o_overflow), 32'd1);
        step(0, 32'h8000_0000, 1);
        chk("ovf_clr", 32'(o_overflow), 32'd0);

        // Bypass: strobe in the final EXEC cycle with pending empty
        step(1, 32'h8000_0241, 0);
        idle(L - 1);
        step(1, 32'h8000_0255, 0);
        chk("bypass_data", 32'(o_lcd_data), 32'h55);
        chk("bypass_busy", 32'(o_busy), 32'd1);
        idle(L + 2);

        // Final EXEC cycle strobe with pending full: all three execute
        step(1, 32'h8000_0241, 0);
        step(1, 32'h8000_0242, 0);
        idle(L - 2);
        step(1, 32'h8000_0243, 0);
        chk("pfull_data", 32'(o_lcd_data), 32'h42);
        chk("pfull_ovf", 32'(o_overflow), 32'd0);
        s3 = 0;
        for (int cyc = L + 2; cyc <= 3 * L + 2; cyc++) begin
            step(0, 32'h8000_0000, 0);
            if (o_lcd_data == 8'h43 && s3 == 0) s3 = cyc;
        end
        chk("pfull_third_setup", s3, 2 * L + 1);
        chk("pfull_ovf_end", 32'(o_overflow), 32'd0);
        chk("pfull_idle", 32'(o_busy), 32'd0);

        // Reset mid-PULSE truncates EN at once
        step(1, 32'h8000_0241, 0);
        idle(7);
        chk("rst_pre_en", 32'(o_lcd_en), 32'd1);
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge i_clk); @(negedge i_clk);
        check_all();
        i_reset = 1'b1;
        step(1, 32'h8000_0230, 0);
        first_en = 0; en_cnt = 0;
        for (int cyc = 2; cyc <= L + 2; cyc++) begin
            step(0, 32'h8000_0000, 0);
            if (o_lcd_en) begin
                if (first_en == 0) first_en = cyc;
                en_cnt++;
            end
        end
        chk("rst_after_en_first", first_en, TS + 1);
        chk("rst_after_en_width", en_cnt, TE);
        chk("rst_after_data", 32'(o_lcd_data), 32'h30);

        // Drop coincident with overflow clear: set wins
        step(1, 32'h8000_0241, 0);
        step(1, 32'h8000_0242, 0);
        step(1, 32'h8000_0243, 1);
        chk("drop_vs_clr", 32'(o_overflow), 32'd1);
        step(0, 32'h8000_0000, 1);
        idle(2 * L + 2);

        // Random traffic, biased towards final-EXEC-cycle strobes and long commands
        for (int n = 0; n < 4000; n++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                w[9] = 1'b0;
                w[7:0] = 8'($urandom_range(1, 3));
            end
            stb = ($urandom_range(0, 14) == 0);
            if (m_act && edge_n + 1 == m_start + cmd_len(m_cmd) && $urandom_range(0, 1) == 1) stb = 1;
            clr = ($urandom_range(0, 24) == 0);
            step(stb, w, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
